collision_checker: RTL and testbench



---
 rtl/collision_checker.sv | 219 +++++++++++++++++++++
 tb/tb_collision_checker.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/collision_checker.sv
// Per-frame T-rex vs leftmost-obstacle collision test: bounding-box
// pre-check, then a serial one-pair-per-clock box scan; sticky crash.
package obstacle_pkg;
  localparam int COLLISION_BOX_COUNT = 6;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [9:0] width;
    logic [9:0] height;
  } collision_box_t;
endpackage

module collision_checker
  import obstacle_pkg::*;
#(
  parameter int TREX_BOX_COUNT = 6,
  parameter int OBS_BOX_COUNT  = COLLISION_BOX_COUNT,
  parameter int GAME_WIDTH     = 640
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                check,
  input  logic                restart,
  input  logic                obstacle_valid,
  input  logic signed [10:0]  obstacle_x_pos,
  input  logic [9:0]          obstacle_y_pos,
  input  logic [9:0]          obstacle_width,
  input  logic [9:0]          obstacle_height,
  input  collision_box_t      obstacle_box [OBS_BOX_COUNT],
  input  logic signed [10:0]  trex_x_pos,
  input  logic [9:0]          trex_y_pos,
  input  logic [9:0]          trex_width,
  input  logic [9:0]          trex_height,
  input  collision_box_t      trex_box [TREX_BOX_COUNT],
  output logic                busy,
  output logic                done,
  output logic                crash
);

  localparam int TW = (TREX_BOX_COUNT > 1) ? $clog2(TREX_BOX_COUNT) : 1;
  localparam int OW = (OBS_BOX_COUNT > 1) ? $clog2(OBS_BOX_COUNT) : 1;
  localparam logic [TW-1:0] TLAST = TW'(TREX_BOX_COUNT - 1);
  localparam logic [OW-1:0] OLAST = OW'(OBS_BOX_COUNT - 1);

  if (GAME_WIDTH < 1 || GAME_WIDTH > 1023) begin : g_bad_width
    $error("GAME_WIDTH must fit the 10-bit playfield");
  end

  typedef logic signed [12:0] coord_t;

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    OUTER,
    PAIRS,
    FINISH
  } state_t;

  function automatic coord_t sx(input logic signed [10:0] p);
    return {{2{p[10]}}, p};
  endfunction

  function automatic coord_t zx(input logic [9:0] v);
    return {3'b000, v};
  endfunction

  function automatic coord_t trim(input coord_t l);
    return (l > 13'sd1) ? l - 13'sd2 : '0;
  endfunction

  // Strict compares: boxes that only share an edge do not overlap.
  function automatic logic overlap(
    input coord_t ax, input coord_t ay,
    input coord_t aw, input coord_t ah,
    input coord_t bx, input coord_t by,
    input coord_t bw, input coord_t bh
  );
    logic nz;
    nz = (aw != '0) && (ah != '0) && (bw != '0) && (bh != '0);
    return nz
      && (ax < bx + bw) && (ax + aw > bx)
      && (ay < by + bh) && (ay + ah > by);
  endfunction

  state_t               state_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 crash_q;
  logic                 hit_q;
  logic [TW-1:0]        ti_q;
  logic [OW-1:0]        oj_q;

  logic signed [10:0]   obs_x_q;
  logic [9:0]           obs_y_q;
  logic [9:0]           obs_w_q;
  logic [9:0]           obs_h_q;
  collision_box_t       obs_box_q [OBS_BOX_COUNT];
  logic signed [10:0]   trex_x_q;
  logic [9:0]           trex_y_q;
  logic [9:0]           trex_w_q;
  logic [9:0]           trex_h_q;
  collision_box_t       trex_box_q [TREX_BOX_COUNT];

  coord_t               tox_q, toy_q, tow_q, toh_q;
  coord_t               oox_q, ooy_q, oow_q, ooh_q;

  logic                 outer_hit_d;
  logic                 pair_hit_d;
  collision_box_t       tb_d;
  collision_box_t       ob_d;

  always_comb begin
    outer_hit_d = overlap(tox_q, toy_q, tow_q, toh_q,
                          oox_q, ooy_q, oow_q, ooh_q);
    tb_d = trex_box_q[ti_q];
    ob_d = obs_box_q[oj_q];
    pair_hit_d = overlap(
      sx(trex_x_q) + zx(tb_d.x), zx(trex_y_q) + zx(tb_d.y),
      zx(tb_d.width), zx(tb_d.height),
      sx(obs_x_q) + zx(ob_d.x), zx(obs_y_q) + zx(ob_d.y),
      zx(ob_d.width), zx(ob_d.height));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      crash_q  <= 1'b0;
      hit_q    <= 1'b0;
      ti_q     <= '0;
      oj_q     <= '0;
      obs_x_q  <= '0;
      obs_y_q  <= '0;
      obs_w_q  <= '0;
      obs_h_q  <= '0;
      trex_x_q <= '0;
      trex_y_q <= '0;
      trex_w_q <= '0;
      trex_h_q <= '0;
      for (int n = 0; n < OBS_BOX_COUNT; n++) obs_box_q[n] <= '0;
      for (int n = 0; n < TREX_BOX_COUNT; n++) trex_box_q[n] <= '0;
      tox_q <= '0; toy_q <= '0; tow_q <= '0; toh_q <= '0;
      oox_q <= '0; ooy_q <= '0; oow_q <= '0; ooh_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (restart) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
        crash_q <= 1'b0;
        hit_q   <= 1'b0;
        ti_q    <= '0;
        oj_q    <= '0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (check && !crash_q) begin
              busy_q     <= 1'b1;
              hit_q      <= 1'b0;
              obs_x_q    <= obstacle_x_pos;
              obs_y_q    <= obstacle_y_pos;
              obs_w_q    <= obstacle_width;
              obs_h_q    <= obstacle_height;
              obs_box_q  <= obstacle_box;
              trex_x_q   <= trex_x_pos;
              trex_y_q   <= trex_y_pos;
              trex_w_q   <= trex_width;
              trex_h_q   <= trex_height;
              trex_box_q <= trex_box;
              state_q    <= obstacle_valid ? CAPTURE : FINISH;
            end
          end
          CAPTURE: begin
            // Pre-check boxes shrink by 1 px per side.
            tox_q   <= sx(trex_x_q) + 13'sd1;
            toy_q   <= zx(trex_y_q) + 13'sd1;
            tow_q   <= trim(zx(trex_w_q));
            toh_q   <= trim(zx(trex_h_q));
            oox_q   <= sx(obs_x_q) + 13'sd1;
            ooy_q   <= zx(obs_y_q) + 13'sd1;
            oow_q   <= trim(zx(obs_w_q));
            ooh_q   <= trim(zx(obs_h_q));
            state_q <= OUTER;
          end
          OUTER: begin
            ti_q    <= '0;
            oj_q    <= '0;
            state_q <= outer_hit_d ? PAIRS : FINISH;
          end
          PAIRS: begin
            if (pair_hit_d) begin
              hit_q   <= 1'b1;
              state_q <= FINISH;
            end else if (oj_q == OLAST) begin
              oj_q <= '0;
              if (ti_q == TLAST) state_q <= FINISH;
              else ti_q <= ti_q + 1'b1;
            end else begin
              oj_q <= oj_q + 1'b1;
            end
          end
          FINISH: begin
            done_q  <= 1'b1;
            crash_q <= crash_q | hit_q;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign crash = crash_q;

endmodule

// File: tb/tb_collision_checker.sv
// Directed bench for collision_checker: latency, hit/miss, edges,
// sticky crash, restart, async reset.
module tb_collision_checker;
  import obstacle_pkg::*;

  logic               clk;
  logic               rst;
  logic               check;
  logic               restart;
  logic               obstacle_valid;
  logic signed [10:0] obstacle_x_pos;
  logic [9:0]         obstacle_y_pos;
  logic [9:0]         obstacle_width;
  logic [9:0]         obstacle_height;
  collision_box_t     obstacle_box [6];
  logic signed [10:0] trex_x_pos;
  logic [9:0]         trex_y_pos;
  logic [9:0]         trex_width;
  logic [9:0]         trex_height;
  collision_box_t     trex_box [6];
  logic               busy;
  logic               done;
  logic               crash;

  int n_checks = 0;
  int n_fail   = 0;

  collision_checker dut (
    .clk             (clk),
    .rst             (rst),
    .check           (check),
    .restart         (restart),
    .obstacle_valid  (obstacle_valid),
    .obstacle_x_pos  (obstacle_x_pos),
    .obstacle_y_pos  (obstacle_y_pos),
    .obstacle_width  (obstacle_width),
    .obstacle_height (obstacle_height),
    .obstacle_box    (obstacle_box),
    .trex_x_pos      (trex_x_pos),
    .trex_y_pos      (trex_y_pos),
    .trex_width      (trex_width),
    .trex_height     (trex_height),
    .trex_box        (trex_box),
    .busy            (busy),
    .done            (done),
    .crash           (crash)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic collision_box_t mk(input int x, input int y,
                                        input int w, input int h);
    collision_box_t b;
    b.x = 10'(x);
    b.y = 10'(y);
    b.width = 10'(w);
    b.height = 10'(h);
    return b;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic base_setup();
    obstacle_valid  = 1'b1;
    trex_x_pos      = 11'sd100;
    trex_y_pos      = 10'd100;
    trex_width      = 10'd44;
    trex_height     = 10'd47;
    obstacle_y_pos  = 10'd105;
    obstacle_width  = 10'd20;
    obstacle_height = 10'd20;
    obstacle_x_pos  = 11'sd105;
    for (int n = 0; n < 6; n++) begin
      trex_box[n]     = mk(0, 0, 0, 0);
      obstacle_box[n] = mk(0, 0, 0, 0);
    end
  endtask

  // Pulse check, return edges from accept to the edge that shows done.
  task automatic run_check(output int lat);
    check = 1'b1;
    tick();
    check = 1'b0;
    lat = 0;
    for (int n = 1; n <= 100; n++) begin
      tick();
      if (done) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic do_restart();
    restart = 1'b1;
    tick();
    restart = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    check = 1'b0;
    restart = 1'b0;
    base_setup();
    repeat (2) tick();
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_busy: got %b want 0", busy);
    end
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_done: got %b want 0", done);
    end
    n_checks++;
    if (crash !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_crash: got %b want 0", crash);
    end
    rst = 1'b1;
    repeat (2) tick();
    n_checks++;
    if ({busy, done, crash} !== 3'b000) begin
      n_fail++;
      $display("FAIL idle_outputs: got %b want 000", {busy, done, crash});
    end
  endtask

  task automatic test_outer_miss();
    int lat;
    base_setup();
    trex_x_pos     = 11'sd50;
    obstacle_x_pos = 11'sd300;
    trex_box[0]     = mk(0, 0, 44, 47);
    obstacle_box[0] = mk(0, 0, 20, 20);
    run_check(lat);
    n_checks++;
    if (lat !== 3) begin
      n_fail++;
      $display("FAIL outer_miss_latency: got %0d want 3", lat);
    end
    n_checks++;
    if (crash !== 1'b0) begin
      n_fail++;
      $display("FAIL outer_miss_crash: got %b want 0", crash);
    end
    tick();
    n_checks++;
    if ({busy, done} !== 2'b00) begin
      n_fail++;
      $display("FAIL done_pulse_width: got busy,done=%b want 00", {busy, done});
    end
  endtask

  task automatic test_first_pair();
    int lat;
    base_setup();
    trex_box[0]     = mk(0, 0, 10, 10);
    obstacle_box[0] = mk(0, 0, 10, 10);
    run_check(lat);
    n_checks++;
    if (lat !== 4) begin
      n_fail++;
      $display("FAIL first_pair_latency: got %0d want 4", lat);
    end
    n_checks++;
    if (crash !== 1'b1) begin
      n_fail++;
      $display("FAIL first_pair_crash: got %b want 1", crash);
    end
    do_restart();
  endtask

  task automatic test_later_pair();
    int lat;
    base_setup();
    trex_box[1]     = mk(0, 0, 10, 10);
    obstacle_box[1] = mk(0, 0, 10, 10);
    run_check(lat);
    n_checks++;
    if (lat !== 11) begin
      n_fail++;
      $display("FAIL pair7_latency: got %0d want 11", lat);
    end
    n_checks++;
    if (crash !== 1'b1) begin
      n_fail++;
      $display("FAIL pair7_crash: got %b want 1", crash);
    end
    do_restart();
    n_checks++;
    if (crash !== 1'b0) begin
      n_fail++;
      $display("FAIL restart_clears: got %b want 0", crash);
    end
  endtask

  task automatic test_all_disjoint();
    int lat;
    base_setup();
    obstacle_x_pos  = 11'sd120;
    obstacle_y_pos  = 10'd120;
    obstacle_width  = 10'd40;
    obstacle_height = 10'd40;
    for (int n = 0; n < 6; n++) begin
      trex_box[n]     = mk(0, 0, 10, 10);
      obstacle_box[n] = mk(30, 30, 10, 10);
    end
    run_check(lat);
    n_checks++;
    if (lat !== 39) begin
      n_fail++;
      $display("FAIL full_scan_latency: got %0d want 39", lat);
    end
    n_checks++;
    if (crash !== 1'b0) begin
      n_fail++;
      $display("FAIL full_scan_crash: got %b want 0", crash);
    end
  endtask

  task automatic test_edge_touch();
    int lat;
    base_setup();
    obstacle_x_pos  = 11'sd110;
    obstacle_y_pos  = 10'd100;
    trex_box[0]     = mk(0, 0, 10, 10);
    obstacle_box[0] = mk(0, 0, 10, 10);
    run_check(lat);
    n_checks++;
    if (lat !== 39 || crash !== 1'b0) begin
      n_fail++;
      $display("FAIL edge_touch: got lat=%0d crash=%b want 39,0", lat, crash);
    end
    obstacle_x_pos = 11'sd109;
    run_check(lat);
    n_checks++;
    if (lat !== 4 || crash !== 1'b1) begin
      n_fail++;
      $display("FAIL edge_overlap: got lat=%0d crash=%b want 4,1", lat, crash);
    end
    do_restart();
  endtask

  task automatic test_negative_x();
    int lat;
    base_setup();
    trex_x_pos      = 11'sd0;
    obstacle_x_pos  = -11'sd5;
    obstacle_y_pos  = 10'd100;
    trex_box[0]     = mk(0, 0, 10, 10);
    obstacle_box[0] = mk(0, 0, 20, 20);
    run_check(lat);
    n_checks++;
    if (lat !== 4 || crash !== 1'b1) begin
      n_fail++;
      $display("FAIL negative_x: got lat=%0d crash=%b want 4,1", lat, crash);
    end
    do_restart();
  endtask

  task automatic test_invalid_obstacle();
    int lat;
    base_setup();
    obstacle_valid  = 1'b0;
    trex_box[0]     = mk(0, 0, 10, 10);
    obstacle_box[0] = mk(0, 0, 10, 10);
    run_check(lat);
    n_checks++;
    if (lat !== 1 || crash !== 1'b0) begin
      n_fail++;
      $display("FAIL invalid_obstacle: got lat=%0d crash=%b want 1,0", lat, crash);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    int dones;
    base_setup();
    trex_box[0]     = mk(0, 0, 10, 10);
    obstacle_box[0] = mk(0, 0, 10, 10);
    check = 1'b1;
    tick();
    // Second check while busy, and moved obstacle: both must be ignored.
    obstacle_x_pos = 11'sd600;
    tick();
    check = 1'b0;
    lat = 0;
    for (int n = 2; n <= 100; n++) begin
      tick();
      if (done) begin
        lat = n;
        break;
      end
    end
    n_checks++;
    if (lat !== 4 || crash !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_check_capture: got lat=%0d crash=%b want 4,1", lat, crash);
    end
    dones = 0;
    for (int n = 0; n < 12; n++) begin
      tick();
      if (done) dones++;
    end
    n_checks++;
    if (dones !== 0) begin
      n_fail++;
      $display("FAIL busy_check_queued: got %0d extra dones want 0", dones);
    end
    check = 1'b1;
    tick();
    check = 1'b0;
    dones = 0;
    for (int n = 0; n < 8; n++) begin
      if (busy || done) dones++;
      tick();
    end
    n_checks++;
    if (dones !== 0) begin
      n_fail++;
      $display("FAIL check_while_crashed: got %0d active cycles want 0", dones);
    end
    restart = 1'b1;
    check = 1'b1;
    tick();
    restart = 1'b0;
    check = 1'b0;
    n_checks++;
    if ({crash, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL restart_wins: got crash,busy=%b want 00", {crash, busy});
    end
    base_setup();
    trex_x_pos     = 11'sd50;
    obstacle_x_pos = 11'sd300;
    run_check(lat);
    n_checks++;
    if (lat !== 3 || crash !== 1'b0) begin
      n_fail++;
      $display("FAIL new_check_after_restart: got lat=%0d crash=%b want 3,0", lat, crash);
    end
  endtask

  task automatic test_restart_abort();
    int dones;
    base_setup();
    obstacle_x_pos  = 11'sd120;
    obstacle_y_pos  = 10'd120;
    obstacle_width  = 10'd40;
    obstacle_height = 10'd40;
    trex_box[0]     = mk(0, 0, 10, 10);
    obstacle_box[0] = mk(30, 30, 10, 10);
    check = 1'b1;
    tick();
    check = 1'b0;
    repeat (6) tick();
    do_restart();
    dones = 0;
    for (int n = 0; n < 45; n++) begin
      if (busy || done) dones++;
      tick();
    end
    n_checks++;
    if (dones !== 0) begin
      n_fail++;
      $display("FAIL restart_abort: got %0d active cycles want 0", dones);
    end
  endtask

  task automatic test_async_reset();
    base_setup();
    trex_box[0]     = mk(0, 0, 10, 10);
    obstacle_box[0] = mk(0, 0, 10, 10);
    obstacle_box[5] = mk(500, 500, 10, 10);
    trex_box[5]     = mk(0, 0, 10, 10);
    obstacle_box[0] = mk(30, 0, 10, 10);
    check = 1'b1;
    tick();
    check = 1'b0;
    repeat (5) tick();
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_busy: got %b want 1", busy);
    end
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, crash} !== 3'b000) begin
      n_fail++;
      $display("FAIL async_reset: got %b want 000", {busy, done, crash});
    end
    tick();
    rst = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_outer_miss();
    test_first_pair();
    test_later_pair();
    test_all_disjoint();
    test_edge_touch();
    test_negative_x();
    test_invalid_obstacle();
    test_back_to_back();
    test_restart_abort();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
